clock_divider_prog: RTL

- Runtime-programmable clock divider, the parametrised successor to the fixed divide-by-N block.
- Divides `clk` by a run-time ratio `DIV`, with a programmable high-phase length `HIGH`.
- Provides a valid/ready configuration handshake; new settings apply only at period boundaries, so `clk_out` never glitches.
- Start/stop is glitch-free and a per-period tick is provided; it sits beside the clock-generation logic feeding slow peripherals and strobe consumers.

---
 rtl/clock_divider_pkg.sv | 24 ++
 rtl/clock_divider_prog_if.sv | 33 +++
 rtl/clock_divider_cfg_shadow.sv | 54 +++++
 rtl/clock_divider_prog.sv | 85 ++++++++
 4 files changed

// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg: shared FSM state type, ratio limit and configuration sanitising
// Contents:
//   state_t  - divider FSM states (IDLE, RUN, STOPPING)
//   MIN_DIV  - smallest legal division ratio
//   sanitise - clamps a requested {div, high} pair of width w into the legal range
package clock_divider_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    localparam int unsigned MIN_DIV = 2;

    // Returns {div, high} packed as two 32-bit halves; callers keep the low w bits of each.
    // Legal results satisfy MIN_DIV <= div and 1 <= high <= div-1.
    function automatic logic [63:0] sanitise(input int unsigned w, input logic [31:0] d, input logic [31:0] h);
        logic [31:0] m, dd, hh;
        m  = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        dd = d & m;
        hh = h & m;
        dd = (dd < MIN_DIV) ? MIN_DIV : dd;
        hh = (hh == 32'd0) ? 32'd1 : ((hh >= dd) ? dd - 32'd1 : hh);
        return {dd, hh};
    endfunction

endpackage

// File: rtl/clock_divider_prog_if.sv
// clock_divider_prog_if: run request, configuration handshake and divided-clock outputs
// Signals:
//   en          - run request (level)
//   cfg_valid   - new configuration offered
//   cfg_div     - requested ratio
//   cfg_high    - requested high-phase length
//   cfg_ready   - shadow slot free
//   clk_out     - divided clock
//   period_tick - pulse in the last cycle of each period
//   running     - divider is in RUN or STOPPING
// Modports: master drives requests/configuration, slave is the divider.
interface clock_divider_prog_if #(parameter int W = 8);

    logic         en;
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic [W-1:0] cfg_high;
    logic         cfg_ready;
    logic         clk_out;
    logic         period_tick;
    logic         running;

    modport master (
        output en, cfg_valid, cfg_div, cfg_high,
        input  cfg_ready, clk_out, period_tick, running
    );

    modport slave (
        input  en, cfg_valid, cfg_div, cfg_high,
        output cfg_ready, clk_out, period_tick, running
    );

endinterface

// File: rtl/clock_divider_cfg_shadow.sv
// clock_divider_cfg_shadow: single-slot configuration shadow with sanitising at capture
// Ports:
//   clk, rstn           - clock, asynchronous active-low reset
//   cfg_valid           - configuration offered
//   cfg_div, cfg_high   - requested ratio / high-phase length (raw)
//   apply               - period boundary (or idle): active registers may load this cycle
//   cfg_ready           - shadow empty; handshake when cfg_valid && cfg_ready
//   upd                 - a new configuration is available to load this cycle
//   upd_div, upd_high   - sanitised values to load when apply && upd
module clock_divider_cfg_shadow
    import clock_divider_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    input  logic [W-1:0] cfg_high,
    input  logic         apply,
    output logic         cfg_ready,
    output logic         upd,
    output logic [W-1:0] upd_div,
    output logic [W-1:0] upd_high
);

    logic [63:0]  san;
    logic [W-1:0] sh_div, sh_high;
    logic         hs;

    assign san = sanitise(W, 32'(cfg_div), 32'(cfg_high));
    assign hs  = cfg_valid && cfg_ready;

    // A pending shadow is loaded at the boundary; with the slot empty, a handshake
    // landing on the boundary (or in idle) bypasses the slot and loads directly.
    assign upd      = !cfg_ready || hs;
    assign upd_div  = cfg_ready ? W'(san[63:32]) : sh_div;
    assign upd_high = cfg_ready ? W'(san[31:0])  : sh_high;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_ready <= 1'b1;
            sh_div    <= '0;
            sh_high   <= '0;
        end else if (apply) begin
            cfg_ready <= 1'b1;
        end else if (hs) begin
            cfg_ready <= 1'b0;
            sh_div    <= W'(san[63:32]);
            sh_high   <= W'(san[31:0]);
        end
    end

endmodule

// File: rtl/clock_divider_prog.sv
// clock_divider_prog: run-time programmable clock divider with glitch-free start/stop
// Ports:
//   clk   - single clock
//   rstn  - asynchronous active-low reset
//   bus   - clock_divider_prog_if.slave: en, cfg_valid/cfg_div/cfg_high/cfg_ready,
//           clk_out, period_tick, running (all outputs registered)
// Parameters: W counter/config width, DEF_DIV / DEF_HIGH active settings after reset.
module clock_divider_prog
    import clock_divider_pkg::*;
#(
    parameter int W        = 8,
    parameter int DEF_DIV  = 4,
    parameter int DEF_HIGH = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    clock_divider_prog_if.slave  bus
);

    localparam logic [63:0]  DEF   = sanitise(W, 32'(DEF_DIV), 32'(DEF_HIGH));
    localparam logic [W-1:0] DEF_D = W'(DEF[63:32]);
    localparam logic [W-1:0] DEF_H = W'(DEF[31:0]);

    state_t       state, state_n;
    logic [W-1:0] cnt, cnt_n;
    logic [W-1:0] div_a, high_a, div_n, high_n;
    logic [W-1:0] upd_div, upd_high;
    logic         act, wrap, apply, upd;
    logic         clk_q, tick_q, run_q;
    logic         clk_n, tick_n, run_n;

    assign act   = state != IDLE;
    assign wrap  = act && cnt == div_a - 1'b1;
    assign apply = !act || wrap;

    clock_divider_cfg_shadow #(.W(W)) u_shadow (
        .clk       (clk),
        .rstn      (rstn),
        .cfg_valid (bus.cfg_valid),
        .cfg_div   (bus.cfg_div),
        .cfg_high  (bus.cfg_high),
        .apply     (apply),
        .cfg_ready (bus.cfg_ready),
        .upd       (upd),
        .upd_div   (upd_div),
        .upd_high  (upd_high)
    );

    // Outputs are computed from next-cycle state so that clk_out, period_tick and
    // running come straight from flops and reflect any configuration loaded this edge.
    always_comb begin
        div_n   = (apply && upd) ? upd_div  : div_a;
        high_n  = (apply && upd) ? upd_high : high_a;
        state_n = bus.en ? RUN : ((act && !wrap) ? STOPPING : IDLE);
        cnt_n   = apply ? '0 : cnt + 1'b1;
        run_n   = state_n != IDLE;
        clk_n   = run_n && cnt_n < high_n;
        tick_n  = run_n && cnt_n == div_n - 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            div_a  <= DEF_D;
            high_a <= DEF_H;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            div_a  <= div_n;
            high_a <= high_n;
            clk_q  <= clk_n;
            tick_q <= tick_n;
            run_q  <= run_n;
        end
    end

    assign bus.clk_out     = clk_q;
    assign bus.period_tick = tick_q;
    assign bus.running     = run_q;

endmodule
